// File: rtl/req_enc8to3.sv
// Sequential 8-to-3 request encoder: latches request strobes into a pending
// register and presents one selected source index until the consumer acks it.
module req_enc8to3 #(
    parameter bit ROUND_ROBIN = 1'b0
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [0:7] Req,
    input  logic       Ack,
    input  logic       Clr,
    output logic [2:0] W,
    output logic       Valid,
    output logic [0:7] Pending,
    output logic       Overrun
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t     state;
    logic [2:0] last;

    logic       ack_take;
    logic [0:7] clr_mask;
    logic [0:7] cand;
    logic [2:0] scan_base;
    logic [2:0] scan_idx;
    logic [2:0] sel_idx;
    logic       sel_found;

    // An ack only counts while a grant is presented; a flush overrides it.
    always_comb begin
        ack_take = (state == GRANT) && Ack && !Clr;
        clr_mask = '0;
        if (ack_take) begin
            clr_mask[W] = 1'b1;
        end
        cand = Pending | Req;
    end

    // Fixed priority is a rotating scan that always starts just after index 7.
    always_comb begin
        scan_base = ROUND_ROBIN ? last : 3'd7;
        scan_idx  = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            scan_idx = scan_base + 3'(k);
            if (!sel_found && cand[scan_idx]) begin
                sel_idx   = scan_idx;
                sel_found = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= IDLE;
            W       <= 3'b000;
            Valid   <= 1'b0;
            Pending <= '0;
            Overrun <= 1'b0;
            last    <= 3'b111;
        end else begin
            Overrun <= !Clr && ((Req & Pending & ~clr_mask) != '0);
            if (Clr) begin
                Pending <= '0;
                Valid   <= 1'b0;
                state   <= IDLE;
            end else begin
                // Set wins: a request on the acked bit re-arms it.
                Pending <= (Pending & ~clr_mask) | Req;
                case (state)
                    IDLE: begin
                        if (sel_found) begin
                            W     <= sel_idx;
                            Valid <= 1'b1;
                            state <= GRANT;
                        end
                    end
                    GRANT: begin
                        if (ack_take) begin
                            last  <= W;
                            Valid <= 1'b0;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        Valid <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_req_enc8to3.sv
// Scoreboarded bench driving a fixed-priority and a round-robin encoder with
// identical stimulus and comparing both against a behavioural model.
module tb_req_enc8to3;

    logic       clock = 1'b0;
    logic       resetn;
    logic [0:7] req;
    logic       ack;
    logic       clr;

    logic [2:0] w_fp, w_rr;
    logic       valid_fp, valid_rr;
    logic [0:7] pending_fp, pending_rr;
    logic       overrun_fp, overrun_rr;

    int check_count = 0;
    int error_count = 0;

    typedef struct {
        logic [0:7] pend;
        logic [2:0] w;
        logic       valid;
        logic       ovr;
        logic [2:0] last;
    } model_t;

    typedef struct {
        model_t fp;
        model_t rr;
    } expect_t;

    model_t  m_fp, m_rr;
    expect_t sb[$];

    always #5 clock = ~clock;

    req_enc8to3 #(.ROUND_ROBIN(1'b0)) dut_fp (
        .Clock(clock), .Resetn(resetn), .Req(req), .Ack(ack), .Clr(clr),
        .W(w_fp), .Valid(valid_fp), .Pending(pending_fp), .Overrun(overrun_fp)
    );

    req_enc8to3 #(.ROUND_ROBIN(1'b1)) dut_rr (
        .Clock(clock), .Resetn(resetn), .Req(req), .Ack(ack), .Clr(clr),
        .W(w_rr), .Valid(valid_rr), .Pending(pending_rr), .Overrun(overrun_rr)
    );

    function automatic model_t model_reset();
        model_t m;
        m.pend  = '0;
        m.w     = 3'd0;
        m.valid = 1'b0;
        m.ovr   = 1'b0;
        m.last  = 3'd7;
        return m;
    endfunction

    // One clock edge of the encoder as seen from its ports.
    function automatic model_t model_step(model_t m, bit rr, logic [0:7] r, logic a, logic c);
        model_t     n;
        logic [0:7] hit;
        logic [0:7] cand;
        bit         take;
        bit         found;
        int         start;
        int         idx;
        n     = m;
        hit   = '0;
        take  = m.valid && a && !c;
        if (take) hit[m.w] = 1'b1;
        n.ovr = !c && ((r & m.pend & ~hit) != 8'd0);
        if (c) begin
            n.pend  = '0;
            n.valid = 1'b0;
        end else begin
            n.pend = (m.pend & ~hit) | r;
            if (take) begin
                n.valid = 1'b0;
                n.last  = m.w;
            end else if (!m.valid) begin
                cand  = m.pend | r;
                start = rr ? (int'(m.last) + 1) % 8 : 0;
                found = 0;
                for (int k = 0; k < 8; k++) begin
                    idx = (start + k) % 8;
                    if (!found && cand[idx]) begin
                        found   = 1;
                        n.w     = 3'(idx);
                        n.valid = 1'b1;
                    end
                end
            end
        end
        return n;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic compareModel(input string who, input model_t e, input logic [2:0] w,
                                input logic v, input logic [0:7] p, input logic o);
        checkOutput({who, ".Valid"}, 16'(v), 16'(e.valid));
        checkOutput({who, ".W"}, 16'(w), 16'(e.w));
        checkOutput({who, ".Pending"}, 16'(p), 16'(e.pend));
        checkOutput({who, ".Overrun"}, 16'(o), 16'(e.ovr));
    endtask

    // Drive one cycle of inputs, push the predicted result, then score it.
    task automatic applyStimulus(input logic [0:7] r, input logic a, input logic c);
        expect_t e;
        @(negedge clock);
        req = r;
        ack = a;
        clr = c;
        m_fp = model_step(m_fp, 1'b0, r, a, c);
        m_rr = model_step(m_rr, 1'b1, r, a, c);
        sb.push_back('{m_fp, m_rr});
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            compareModel("fp", e.fp, w_fp, valid_fp, pending_fp, overrun_fp);
            compareModel("rr", e.rr, w_rr, valid_rr, pending_rr, overrun_rr);
        end
    endtask

    // Reset lands between edges so its asynchronous effect is visible at once.
    task automatic do_reset();
        @(negedge clock);
        #2;
        resetn = 1'b0;
        req = '0;
        ack = 1'b0;
        clr = 1'b0;
        #1;
        checkOutput("rst.fp.Valid", 16'(valid_fp), 16'd0);
        checkOutput("rst.fp.W", 16'(w_fp), 16'd0);
        checkOutput("rst.fp.Pending", 16'(pending_fp), 16'd0);
        checkOutput("rst.fp.Overrun", 16'(overrun_fp), 16'd0);
        checkOutput("rst.rr.Valid", 16'(valid_rr), 16'd0);
        checkOutput("rst.rr.Pending", 16'(pending_rr), 16'd0);
        m_fp = model_reset();
        m_rr = model_reset();
        sb.delete();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        logic [0:7] r;
        resetn = 1'b1;
        req = '0;
        ack = 1'b0;
        clr = 1'b0;
        m_fp = model_reset();
        m_rr = model_reset();

        do_reset();

        // Single request on index 2, then ack it.
        applyStimulus(8'b00100000, 1'b0, 1'b0);
        checkOutput("idx2.W", 16'(w_fp), 16'd2);
        checkOutput("idx2.Valid", 16'(valid_fp), 16'd1);
        applyStimulus(8'b00000000, 1'b1, 1'b0);
        checkOutput("idx2.ackPending", 16'(pending_fp), 16'd0);

        // Ack while idle is ignored.
        applyStimulus(8'b00000000, 1'b1, 1'b0);

        // Two sources: 1 then 7 in fixed priority.
        applyStimulus(8'b01000001, 1'b0, 1'b0);
        checkOutput("pair.first", 16'(w_fp), 16'd1);
        applyStimulus(8'b00000000, 1'b1, 1'b0);
        applyStimulus(8'b00000000, 1'b0, 1'b0);
        checkOutput("pair.second", 16'(w_fp), 16'd7);
        applyStimulus(8'b00000000, 1'b1, 1'b0);
        checkOutput("pair.drained", 16'(pending_fp), 16'd0);

        // Round-robin walk over all eight sources from Last=7.
        do_reset();
        applyStimulus(8'b11111111, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            checkOutput("rr.seq", 16'(w_rr), 16'(k));
            applyStimulus(8'b00000000, 1'b1, 1'b0);
            if (k < 7) applyStimulus(8'b00000000, 1'b0, 1'b0);
        end
        applyStimulus(8'b10000001, 1'b0, 1'b0);
        checkOutput("rr.wrap", 16'(w_rr), 16'd0);
        applyStimulus(8'b00000000, 1'b1, 1'b0);
        applyStimulus(8'b00000000, 1'b0, 1'b0);
        applyStimulus(8'b00000000, 1'b1, 1'b0);

        // Grant holds against a higher-priority arrival; re-request overruns.
        do_reset();
        applyStimulus(8'b00000100, 1'b0, 1'b0);
        applyStimulus(8'b10000000, 1'b0, 1'b0);
        checkOutput("hold.W", 16'(w_fp), 16'd5);
        applyStimulus(8'b00000100, 1'b0, 1'b0);
        checkOutput("ovr.pulse", 16'(overrun_fp), 16'd1);
        applyStimulus(8'b00000000, 1'b0, 1'b0);
        checkOutput("ovr.oneCycle", 16'(overrun_fp), 16'd0);
        applyStimulus(8'b00000000, 1'b1, 1'b0);
        applyStimulus(8'b00000000, 1'b0, 1'b0);
        checkOutput("hold.next", 16'(w_fp), 16'd0);
        applyStimulus(8'b00000000, 1'b1, 1'b0);

        // Set wins on the ack edge, then a flush beats ack and request.
        do_reset();
        applyStimulus(8'b00010000, 1'b0, 1'b0);
        applyStimulus(8'b00010000, 1'b1, 1'b0);
        checkOutput("setwins.Pending", 16'(pending_fp), 16'(8'b00010000));
        applyStimulus(8'b00000000, 1'b0, 1'b0);
        checkOutput("setwins.regrant", 16'(w_fp), 16'd3);
        applyStimulus(8'b00001000, 1'b1, 1'b1);
        checkOutput("clr.Pending", 16'(pending_fp), 16'd0);
        checkOutput("clr.Overrun", 16'(overrun_fp), 16'd0);
        applyStimulus(8'b00000000, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a grant.
        applyStimulus(8'b00000001, 1'b0, 1'b0);
        do_reset();
        applyStimulus(8'b00000000, 1'b0, 1'b0);
        applyStimulus(8'b00000000, 1'b1, 1'b0);

        // Random traffic with occasional flushes.
        for (int n = 0; n < 300; n++) begin
            for (int b = 0; b < 8; b++) r[b] = ($urandom_range(0, 5) == 0);
            applyStimulus(r, 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0));
        end

        $display("[TB] Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
